// File: rtl/branch_predictor_gshare_if.sv
// rtl/branch_predictor_gshare_if.sv - fetch-side prediction and EX-side resolution signals
interface branch_predictor_gshare_if;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_e;
  logic        cflow_valid;
  logic        cflow_uncond;
  logic        cflow_taken;
  logic [31:0] cflow_target;

  modport master (
    output pc_f, pc_e, cflow_valid, cflow_uncond, cflow_taken, cflow_target,
    input  pred_taken, pred_target
  );

  modport slave (
    input  pc_f, pc_e, cflow_valid, cflow_uncond, cflow_taken, cflow_target,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with tagged direct-mapped BTB
module branch_predictor_gshare #(
  parameter int BHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int BTB_ENTRIES = 64
) (
  input logic                    clk,
  input logic                    rst,
  branch_predictor_gshare_if.slave bus
);
  localparam int BI = $clog2(BHT_ENTRIES);
  localparam int TI = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - TI;

  logic [1:0]    bht        [BHT_ENTRIES];
  logic          btb_valid  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]   btb_target [BTB_ENTRIES];
  logic          btb_uncond [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  logic [31:2] pc_e_r;
  logic        valid_r, uncond_r, taken_r;
  logic [31:0] target_r;

  logic [BI-1:0] f_bht_idx, u_bht_idx;
  logic [TI-1:0] f_btb_idx, u_btb_idx;
  logic          f_hit;
  logic [1:0]    cnt_cur, cnt_next;
  logic [GHR_BITS-1:0] ghr_next;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, bus.pc_e[1:0]};

  // Predict path: purely combinational, sees table state before any same-edge write.
  assign f_bht_idx = bus.pc_f[BI+1:2] ^ BI'(ghr);
  assign f_btb_idx = bus.pc_f[TI+1:2];
  assign f_hit     = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == bus.pc_f[31:TI+2]);

  always_comb begin
    bus.pred_taken  = 1'b0;
    bus.pred_target = bus.pc_f + 32'd4;
    if (!rst && f_hit) begin
      bus.pred_taken  = btb_uncond[f_btb_idx] | bht[f_bht_idx][1];
      bus.pred_target = btb_target[f_btb_idx];
    end
  end

  // Update path indexes with the GHR as it stands at write time, not at predict time.
  assign u_bht_idx = pc_e_r[BI+1:2] ^ BI'(ghr);
  assign u_btb_idx = pc_e_r[TI+1:2];
  assign cnt_cur   = bht[u_bht_idx];
  assign ghr_next  = GHR_BITS'({ghr, taken_r});

  always_comb begin
    cnt_next = cnt_cur;
    if (taken_r) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_e_r   <= '0;
      valid_r  <= 1'b0;
      uncond_r <= 1'b0;
      taken_r  <= 1'b0;
      target_r <= '0;
      ghr      <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else begin
      pc_e_r   <= bus.pc_e[31:2];
      valid_r  <= bus.cflow_valid;
      uncond_r <= bus.cflow_uncond;
      taken_r  <= bus.cflow_taken;
      target_r <= bus.cflow_target;
      if (valid_r && !uncond_r) begin
        bht[u_bht_idx] <= cnt_next;
        ghr            <= ghr_next;
      end
      if (valid_r && taken_r) btb_valid[u_btb_idx] <= 1'b1;
    end
  end

  // BTB payload needs no reset; the valid bit gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst && valid_r && taken_r) begin
      btb_tag[u_btb_idx]    <= pc_e_r[31:TI+2];
      btb_target[u_btb_idx] <= target_r;
      btb_uncond[u_btb_idx] <= uncond_r;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - scoreboard bench with behavioural gshare reference model
module tb_branch_predictor_gshare;
  localparam int BHT = 256;
  localparam int GHR = 8;
  localparam int BTB = 64;
  localparam int TI  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_gshare_if bus();

  branch_predictor_gshare #(
    .BHT_ENTRIES(BHT),
    .GHR_BITS(GHR),
    .BTB_ENTRIES(BTB)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    bit          v, u, t;
    logic [31:0] pc, tgt;
  } upd_t;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] pc;
  } exp_t;

  int          m_cnt  [BHT];
  int          m_ghr;
  bit          m_bv   [BTB];
  logic [31:0] m_btag [BTB];
  logic [31:0] m_btgt [BTB];
  bit          m_bunc [BTB];
  upd_t        m_pend;
  bit          cur_rst;
  upd_t        cur_upd;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int bht_index(logic [31:0] pc);
    return int'((pc >> 2) % BHT) ^ m_ghr;
  endfunction

  function automatic int btb_index(logic [31:0] pc);
    return int'((pc >> 2) % BTB);
  endfunction

  // One rising edge of the reference: apply the pending resolution, then capture the current one.
  task automatic model_edge();
    int i, b;
    if (cur_rst) begin
      for (int k = 0; k < BHT; k++) m_cnt[k] = 1;
      for (int k = 0; k < BTB; k++) m_bv[k] = 0;
      m_ghr  = 0;
      m_pend = '{0, 0, 0, 32'h0, 32'h0};
    end else begin
      if (m_pend.v) begin
        if (!m_pend.u) begin
          i = bht_index(m_pend.pc);
          if (m_pend.t) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          else          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          m_ghr = ((m_ghr * 2) + (m_pend.t ? 1 : 0)) % (1 << GHR);
        end
        if (m_pend.t) begin
          b = btb_index(m_pend.pc);
          m_bv[b]   = 1;
          m_btag[b] = m_pend.pc >> (TI + 2);
          m_btgt[b] = m_pend.tgt;
          m_bunc[b] = m_pend.u;
        end
      end
      m_pend = cur_upd;
    end
  endtask

  function automatic exp_t model_predict(bit r, logic [31:0] pc);
    exp_t e;
    int   b;
    bit   hit;
    e.pc  = pc;
    e.tk  = 1'b0;
    e.tgt = pc + 32'd4;
    b   = btb_index(pc);
    hit = m_bv[b] && (m_btag[b] == (pc >> (TI + 2)));
    if (!r && hit) begin
      e.tk  = m_bunc[b] || (m_cnt[bht_index(pc)] >= 2);
      e.tgt = m_btgt[b];
    end
    return e;
  endfunction

  task automatic step(input bit r, input logic [31:0] pcf, input bit v, input bit u,
                      input bit t, input logic [31:0] pce, input logic [31:0] tgt);
    @(posedge clk);
    model_edge();
    #1;
    rst              = r;
    bus.pc_f         = pcf;
    bus.cflow_valid  = v;
    bus.cflow_uncond = u;
    bus.cflow_taken  = t;
    bus.pc_e         = pce;
    bus.cflow_target = tgt;
    cur_rst = r;
    cur_upd = '{v, u, t, pce, tgt};
    sb.push_back(model_predict(r, pcf));
  endtask

  task automatic idle(input logic [31:0] pcf);
    step(0, pcf, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.pred_taken !== e.tk || bus.pred_target !== e.tgt) begin
          failures++;
          $display("FAIL pred pc_f=%h got taken=%0b target=%h expected taken=%0b target=%h",
                   e.pc, bus.pred_taken, bus.pred_target, e.tk, e.tgt);
        end
      end
    end
  end

  logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h300, 32'h10, 32'h14, 32'h104, 32'h1100, 32'h40};

  initial begin
    logic [31:0] pa, pb;
    bit          v, u, t, r;
    rst = 1'b1;
    bus.pc_f = 32'h0; bus.pc_e = 32'h0;
    bus.cflow_valid = 0; bus.cflow_uncond = 0; bus.cflow_taken = 0; bus.cflow_target = 0;
    cur_rst = 1'b1;
    cur_upd = '{0, 0, 0, 32'h0, 32'h0};

    idle(32'h100);
    step(0, 32'h100, 1, 0, 1, 32'h100, 32'h80);
    idle(32'h100);
    idle(32'h100);
    idle(32'h100);

    step(0, 32'h300, 1, 1, 1, 32'h300, 32'h400);
    idle(32'h300);
    idle(32'h300);
    idle(32'h100);

    step(0, 32'h200, 1, 0, 1, 32'h200, 32'h40);
    idle(32'h200);
    idle(32'h100);
    idle(32'h200);

    step(0, 32'h10, 1, 0, 1, 32'h10, 32'h20);
    for (int k = 0; k < 12; k++) step(0, 32'h10, 1, 0, 0, 32'h10, 32'h0);
    idle(32'h10);
    idle(32'h10);
    for (int k = 0; k < 12; k++) step(0, 32'h10, 1, 0, 1, 32'h10, 32'h20);
    idle(32'h10);
    idle(32'h10);

    step(1, 32'h300, 0, 0, 0, 32'h0, 32'h0);
    idle(32'h300);
    step(0, 32'h300, 1, 1, 1, 32'h300, 32'h500);
    step(1, 32'h300, 1, 1, 1, 32'h300, 32'h600);
    idle(32'h300);
    idle(32'h300);
    idle(32'h300);

    for (int k = 0; k < 1500; k++) begin
      pa = pool[$urandom_range(7)];
      pb = pool[$urandom_range(7)];
      r  = ($urandom_range(199) == 0);
      v  = ($urandom_range(9) < 6);
      u  = ($urandom_range(4) == 0);
      t  = u ? 1'b1 : (($urandom_range(3) != 0) ^ pb[8]);
      step(r, pa, v, u, t, pb, {$urandom_range(32'hFFFF), 2'b00});
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
